// File: rtl/sisc_mem_pkg.sv
// Shared types and defaults for the SISC memory arbiter.
package sisc_mem_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 32;

   // Wide enough for the largest legal memory latency (15).
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_e;

   // Round-robin pick between the two requesters: on a tie the one not
   // served last wins. Only meaningful when at least one request is high.
   function automatic owner_e rr_pick(input logic   i_req,
                                      input logic   d_req,
                                      input owner_e last);
      owner_e win;
      if (i_req && d_req) begin
         if (last == OWN_FETCH) win = OWN_DATA;
         else                   win = OWN_FETCH;
      end else if (d_req) begin
         win = OWN_DATA;
      end else begin
         win = OWN_FETCH;
      end
      return win;
   endfunction

endpackage

// File: rtl/sisc_mem_arb_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory.
interface sisc_mem_arb_if #(
   parameter int AW = sisc_mem_pkg::AW_DEF,
   parameter int DW = sisc_mem_pkg::DW_DEF
);
   // Fetch requester
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt;
   logic          i_rvalid;
   logic [DW-1:0] i_rdata;
   // Data requester
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   // Memory port
   logic          m_en;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   // Status
   logic          busy;

   // Environment side: requesters plus the memory itself.
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      input  m_en, m_we, m_addr, m_wdata, busy
   );

   // Arbiter side.
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      output m_en, m_we, m_addr, m_wdata, busy
   );

endinterface

// File: rtl/sisc_lat_cnt.sv
// Loadable down-counter with a zero flag, used to time the memory latency.
module sisc_lat_cnt
   import sisc_mem_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load wins over decrement; saturate at zero.
   always_comb begin
      // NOTE: default assignment first so every path drives cnt_d (no latch).
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sisc_mem_arb.sv
// Single-port memory arbiter: serialises fetch and data transactions onto
// one fixed-latency memory and returns data/completions to the owner.
module sisc_mem_arb
   import sisc_mem_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int MEM_LAT = 2           // legal range 1..15
) (
   input  logic           clk,
   input  logic           rst,
   sisc_mem_arb_if.slave  bus
);

   // WAIT lasts MEM_LAT cycles: the counter loads in ISSUE and the
   // transaction leaves WAIT in the cycle it reads zero.
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

   state_e        state_q;
   owner_e        owner_q;
   owner_e        last_owner_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          m_en_q;
   logic          i_gnt_q;
   logic          d_gnt_q;
   logic          i_rvalid_q;
   logic          d_rvalid_q;
   logic [DW-1:0] i_rdata_q;
   logic [DW-1:0] d_rdata_q;

   logic          arb_win;
   owner_e        arb_owner;
   owner_e        arb_last;
   logic          arb_we;
   logic [AW-1:0] arb_addr;
   logic [DW-1:0] arb_wdata;

   logic          cnt_zero;

   sisc_lat_cnt u_lat_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (state_q == S_ISSUE),
      .load_val_i (LAT_LOAD),
      .dec_i      (state_q == S_WAIT),
      .zero_o     (cnt_zero)
   );

   // Arbitration on this cycle's requests; in RESP the current owner is
   // the one just served, so it counts as "last" for the tie-break.
   always_comb begin
      arb_last  = (state_q == S_RESP) ? owner_q : last_owner_q;
      arb_win   = bus.i_req | bus.d_req;
      arb_owner = rr_pick(bus.i_req, bus.d_req, arb_last);
      arb_we    = 1'b0;
      arb_addr  = bus.i_addr;
      arb_wdata = '0;
      if (arb_owner == OWN_DATA) begin
         arb_we    = bus.d_we;
         arb_addr  = bus.d_addr;
         arb_wdata = bus.d_wdata;
      end
   end

   // Control FSM with registered strobes, latches and read-data holding.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the transaction latches are reset as well because they
         // drive m_addr/m_wdata directly and every output must read 0.
         state_q      <= S_IDLE;
         owner_q      <= OWN_FETCH;
         last_owner_q <= OWN_FETCH;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         m_en_q       <= 1'b0;
         i_gnt_q      <= 1'b0;
         d_gnt_q      <= 1'b0;
         i_rvalid_q   <= 1'b0;
         d_rvalid_q   <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         m_en_q     <= 1'b0;
         i_gnt_q    <= 1'b0;
         d_gnt_q    <= 1'b0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         case (state_q)
            S_IDLE, S_RESP: begin
               if (state_q == S_RESP) last_owner_q <= owner_q;
               if (arb_win) begin
                  owner_q <= arb_owner;
                  we_q    <= arb_we;
                  addr_q  <= arb_addr;
                  wdata_q <= arb_wdata;
                  m_en_q  <= 1'b1;
                  i_gnt_q <= (arb_owner == OWN_FETCH);
                  d_gnt_q <= (arb_owner == OWN_DATA);
                  state_q <= S_ISSUE;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_zero) begin
                  if (!we_q) begin
                     if (owner_q == OWN_FETCH) i_rdata_q <= bus.m_rdata;
                     else                      d_rdata_q <= bus.m_rdata;
                  end
                  i_rvalid_q <= (owner_q == OWN_FETCH);
                  d_rvalid_q <= (owner_q == OWN_DATA);
                  state_q    <= S_RESP;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.i_gnt    = i_gnt_q;
   assign bus.d_gnt    = d_gnt_q;
   assign bus.i_rvalid = i_rvalid_q;
   assign bus.d_rvalid = d_rvalid_q;
   assign bus.i_rdata  = i_rdata_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.m_en     = m_en_q;
   assign bus.m_we     = m_en_q & we_q;
   assign bus.m_addr   = addr_q;
   assign bus.m_wdata  = wdata_q;
   assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Directed bench for sisc_mem_arb: a MEM_LAT=2 instance for the main
// scenarios and a MEM_LAT=1 instance for the short-latency case.
module tb_sisc_mem_arb;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   sisc_mem_arb_if #(.AW(16), .DW(32)) bus0 ();
   sisc_mem_arb_if #(.AW(16), .DW(32)) bus1 ();

   sisc_mem_arb #(.AW(16), .DW(32), .MEM_LAT(2)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   sisc_mem_arb #(.AW(16), .DW(32), .MEM_LAT(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents (read-only view).
   function automatic logic [31:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0004: return 32'hDEADBEEF;
         16'h0010: return 32'hCAFEF00D;
         default:  return {16'hA5A5, a};
      endcase
   endfunction

   // Memory models: read data valid only in the cycle MEM_LAT after m_en,
   // garbage otherwise so an early or late capture shows up.
   logic [1:0]  pv0 = '0;
   logic [15:0] pa0 [2];
   logic        pv1 = 1'b0;
   logic [15:0] pa1;

   always @(posedge clk) begin
      pv0    <= {pv0[0], bus0.m_en & ~bus0.m_we};
      pa0[0] <= bus0.m_addr;
      pa0[1] <= pa0[0];
      pv1    <= bus1.m_en & ~bus1.m_we;
      pa1    <= bus1.m_addr;
   end

   assign bus0.m_rdata = pv0[1] ? mem_word(pa0[1]) : 32'hBAD0BAD0;
   assign bus1.m_rdata = pv1    ? mem_word(pa1)    : 32'hBAD0BAD0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus0.i_req = 1'b0; bus0.i_addr = '0;
      bus0.d_req = 1'b0; bus0.d_we = 1'b0; bus0.d_addr = '0; bus0.d_wdata = '0;
      bus1.i_req = 1'b0; bus1.i_addr = '0;
      bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
      step();
      step();

      // Reset state
      check("rst_busy",    32'(bus0.busy),     32'h0);
      check("rst_m_en",    32'(bus0.m_en),     32'h0);
      check("rst_gnt",     32'({bus0.i_gnt, bus0.d_gnt}), 32'h0);
      check("rst_rvalid",  32'({bus0.i_rvalid, bus0.d_rvalid}), 32'h0);
      check("rst_i_rdata", bus0.i_rdata,       32'h0);
      check("rst_d_rdata", bus0.d_rdata,       32'h0);
      check("rst_m_addr",  32'(bus0.m_addr),   32'h0);
      rst = 1'b0;

      // Single fetch at 0x0004
      bus0.i_req = 1'b1; bus0.i_addr = 16'h0004;
      step();                                   // cycle 1
      check("f_i_gnt",  32'(bus0.i_gnt),  32'h1);
      check("f_d_gnt",  32'(bus0.d_gnt),  32'h0);
      check("f_m_en",   32'(bus0.m_en),   32'h1);
      check("f_m_we",   32'(bus0.m_we),   32'h0);
      check("f_m_addr", 32'(bus0.m_addr), 32'h0004);
      bus0.i_req = 1'b0;
      step();                                   // cycle 2
      check("f_m_en_c2", 32'(bus0.m_en), 32'h0);
      check("f_busy_c2", 32'(bus0.busy), 32'h1);
      step();                                   // cycle 3
      check("f_rvalid_c3", 32'(bus0.i_rvalid), 32'h0);
      step();                                   // cycle 4
      check("f_rvalid_c4", 32'(bus0.i_rvalid), 32'h1);
      check("f_d_rvalid",  32'(bus0.d_rvalid), 32'h0);
      check("f_rdata",     bus0.i_rdata,       32'hDEADBEEF);
      step();                                   // cycle 5
      check("f_rvalid_c5", 32'(bus0.i_rvalid), 32'h0);
      check("f_busy_c5",   32'(bus0.busy),     32'h0);
      check("f_rdata_hold", bus0.i_rdata,      32'hDEADBEEF);

      // Data load at 0x0020
      bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 16'h0020;
      step();
      check("l_d_gnt", 32'(bus0.d_gnt), 32'h1);
      check("l_m_we",  32'(bus0.m_we),  32'h0);
      bus0.d_req = 1'b0;
      step(); step(); step();                   // cycle 4
      check("l_rvalid", 32'(bus0.d_rvalid), 32'h1);
      check("l_rdata",  bus0.d_rdata,       32'hA5A50020);
      check("l_i_rdata_kept", bus0.i_rdata, 32'hDEADBEEF);
      step();

      // Store 0x12345678 to 0x0020
      bus0.d_req = 1'b1; bus0.d_we = 1'b1; bus0.d_addr = 16'h0020; bus0.d_wdata = 32'h12345678;
      step();                                   // cycle 1
      check("s_d_gnt",   32'(bus0.d_gnt),  32'h1);
      check("s_i_gnt",   32'(bus0.i_gnt),  32'h0);
      check("s_m_en",    32'(bus0.m_en),   32'h1);
      check("s_m_we",    32'(bus0.m_we),   32'h1);
      check("s_m_addr",  32'(bus0.m_addr), 32'h0020);
      check("s_m_wdata", bus0.m_wdata,     32'h12345678);
      bus0.d_req = 1'b0; bus0.d_we = 1'b0; bus0.d_wdata = '0;
      step(); step();                           // cycle 3
      check("s_rvalid_c3", 32'(bus0.d_rvalid), 32'h0);
      step();                                   // cycle 4
      check("s_rvalid_c4", 32'(bus0.d_rvalid), 32'h1);
      check("s_rdata_kept", bus0.d_rdata,      32'hA5A50020);
      step();
      check("s_busy_end", 32'(bus0.busy), 32'h0);

      // Reset during WAIT of a load at 0x0010
      bus0.d_req = 1'b1; bus0.d_addr = 16'h0010;
      step();                                   // cycle 1 ISSUE
      bus0.d_req = 1'b0;
      step();                                   // cycle 2 WAIT
      check("r_busy_wait", 32'(bus0.busy), 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("r_busy",    32'(bus0.busy),     32'h0);
      check("r_rvalid",  32'(bus0.d_rvalid), 32'h0);
      check("r_d_rdata", bus0.d_rdata,       32'h0);
      check("r_i_rdata", bus0.i_rdata,       32'h0);
      step();
      check("r_rvalid_late", 32'(bus0.d_rvalid), 32'h0);
      check("r_busy_late",   32'(bus0.busy),     32'h0);

      // Both requesters held: grants alternate D, I, D, I every 4 cycles
      bus0.i_req = 1'b1; bus0.i_addr = 16'h0004;
      bus0.d_req = 1'b1; bus0.d_addr = 16'h0010; bus0.d_we = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         check($sformatf("rr_d_gnt_c%0d", k), 32'(bus0.d_gnt),
               32'((k % 4 == 1) && (((k - 1) / 4) % 2 == 0)));
         check($sformatf("rr_i_gnt_c%0d", k), 32'(bus0.i_gnt),
               32'((k % 4 == 1) && (((k - 1) / 4) % 2 == 1)));
         check($sformatf("rr_d_rv_c%0d", k), 32'(bus0.d_rvalid),
               32'((k % 4 == 0) && ((k / 4) % 2 == 1)));
         check($sformatf("rr_i_rv_c%0d", k), 32'(bus0.i_rvalid),
               32'((k % 4 == 0) && ((k / 4) % 2 == 0)));
      end
      check("rr_d_rdata", bus0.d_rdata, 32'hCAFEF00D);
      check("rr_i_rdata", bus0.i_rdata, 32'hDEADBEEF);
      bus0.i_req = 1'b0; bus0.d_req = 1'b0;
      step();
      check("rr_busy_end", 32'(bus0.busy), 32'h0);

      // Fetch request pulsed during WAIT of a data load is dropped
      bus0.d_req = 1'b1; bus0.d_addr = 16'h0020;
      step();                                   // cycle 1
      check("p_d_gnt", 32'(bus0.d_gnt), 32'h1);
      bus0.d_req = 1'b0;
      step();                                   // cycle 2 WAIT
      bus0.i_req = 1'b1;
      step();                                   // cycle 3
      bus0.i_req = 1'b0;
      check("p_i_gnt_c3", 32'(bus0.i_gnt), 32'h0);
      step();                                   // cycle 4 RESP
      check("p_d_rvalid", 32'(bus0.d_rvalid), 32'h1);
      check("p_d_rdata",  bus0.d_rdata,       32'hA5A50020);
      check("p_i_gnt_c4", 32'(bus0.i_gnt),    32'h0);
      step();                                   // cycle 5
      check("p_i_gnt_c5", 32'(bus0.i_gnt), 32'h0);
      check("p_busy_c5",  32'(bus0.busy),  32'h0);
      check("p_m_en_c5",  32'(bus0.m_en),  32'h0);

      // MEM_LAT=1 instance: single load at 0x0010
      bus1.d_req = 1'b1; bus1.d_addr = 16'h0010;
      step();                                   // cycle 1
      check("l1_d_gnt", 32'(bus1.d_gnt), 32'h1);
      check("l1_m_en",  32'(bus1.m_en),  32'h1);
      bus1.d_req = 1'b0;
      step();                                   // cycle 2 WAIT
      check("l1_rvalid_c2", 32'(bus1.d_rvalid), 32'h0);
      step();                                   // cycle 3 RESP
      check("l1_rvalid_c3", 32'(bus1.d_rvalid), 32'h1);
      check("l1_rdata",     bus1.d_rdata,       32'hCAFEF00D);
      step();
      check("l1_rvalid_c4", 32'(bus1.d_rvalid), 32'h0);
      check("l1_busy_c4",   32'(bus1.busy),     32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
